pio_cmd_arbiter: RTL and testbench

- Shares the single host command port of the PIO block (action/mindex/index/din in, dout/full/empty out) between NREQ independent requesters, e.g. a program loader, a config engine and per-machine data movers.
- Round-robin arbitration with flow-control awareness: a PUSH is never issued into a full TX FIFO and a PULL is never issued from an empty RX FIFO.
- Routes PULL read data back to the requester that issued the PULL.

---
 rtl/pio_cmd_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_pio_cmd_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_cmd_arbiter.sv
// pio_cmd_arbiter
// Shares the single PIO host command port between NREQ requesters.
// Round-robin arbitration that refuses to push into a full TX FIFO or to
// pull from an empty RX FIFO. Each FIFO access locks its machine for a short
// window that covers the PIO flag-update latency. PULL data is steered back
// to the requester that issued the PULL, two cycles after its grant.

module pio_cmd_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_action,
    input  logic [2*NREQ-1:0]    req_mindex,
    input  logic [5*NREQ-1:0]    req_index,
    input  logic [32*NREQ-1:0]   req_din,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_data,
    output logic [3:0]           pio_action,
    output logic [1:0]           pio_mindex,
    output logic [4:0]           pio_index,
    output logic [31:0]          pio_din,
    input  logic [31:0]          pio_dout,
    input  logic [3:0]           pio_full,
    input  logic [3:0]           pio_empty
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [3:0] ACT_NONE = 4'd0;
    localparam logic [3:0] ACT_PULL = 4'd3;
    localparam logic [3:0] ACT_PUSH = 4'd4;

    // Unpacked per-requester command fields
    logic [3:0]       act_s    [NREQ];
    logic [1:0]       mi_s     [NREQ];
    logic [4:0]       ix_s     [NREQ];
    logic [31:0]      din_s    [NREQ];

    // Arbitration state and results
    logic [PTR_W-1:0] ptr_r;
    logic [1:0]       lock_r   [4];
    logic [NREQ-1:0]  elig_s;
    logic             grant_vld_s;
    logic [PTR_W-1:0] grant_idx_s;
    logic [NREQ-1:0]  grant_oh_s;

    // Winner's command fields
    logic [3:0]       win_action_s;
    logic [1:0]       win_mindex_s;
    logic [4:0]       win_index_s;
    logic [31:0]      win_din_s;
    logic             win_fifo_s;

    // Registered PIO command and PULL response pipeline
    logic [3:0]       pio_action_r;
    logic [1:0]       pio_mindex_r;
    logic [4:0]       pio_index_r;
    logic [31:0]      pio_din_r;
    logic [NREQ-1:0]  pull_oh_r;
    logic [NREQ-1:0]  rsp_valid_r;

    // Slice the flat request buses into per-requester fields
    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            act_s[r] = req_action[4*r +: 4];
            mi_s[r]  = req_mindex[2*r +: 2];
            ix_s[r]  = req_index[5*r +: 5];
            din_s[r] = req_din[32*r +: 32];
        end
    end

    // Eligibility: FIFO actions need a usable FIFO and an unlocked machine
    always_comb begin
        elig_s = '0;
        for (int r = 0; r < NREQ; r++) begin
            case (act_s[r])
                ACT_PUSH: elig_s[r] = req_valid[r] && reset && !pio_full[mi_s[r]]
                                      && (lock_r[mi_s[r]] == 2'd0);
                ACT_PULL: elig_s[r] = req_valid[r] && reset && !pio_empty[mi_s[r]]
                                      && (lock_r[mi_s[r]] == 2'd0);
                default:  elig_s[r] = req_valid[r] && reset;
            endcase
        end
    end

    // Round-robin search starting just after the last granted requester
    always_comb begin
        logic [PTR_W-1:0] cand_v;
        logic             take_v;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand_v      = '0;
        take_v      = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_v      = PTR_W'((int'(ptr_r) + i) % NREQ);
            take_v      = !grant_vld_s && elig_s[cand_v];
            grant_idx_s = take_v ? cand_v : grant_idx_s;
            grant_vld_s = grant_vld_s | take_v;
        end
    end

    // One-hot grant drives the per-requester ready lines
    always_comb begin
        grant_oh_s = '0;
        if (grant_vld_s) begin
            grant_oh_s[grant_idx_s] = 1'b1;
        end else begin
            grant_oh_s = '0;
        end
    end

    // Select the winning requester's command
    always_comb begin
        win_action_s = act_s[grant_idx_s];
        win_mindex_s = mi_s[grant_idx_s];
        win_index_s  = ix_s[grant_idx_s];
        win_din_s    = din_s[grant_idx_s];
        win_fifo_s   = (act_s[grant_idx_s] == ACT_PUSH) || (act_s[grant_idx_s] == ACT_PULL);
    end

    // Round-robin pointer and the one-cycle PIO command register
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_r        <= PTR_W'(NREQ - 1);
            pio_action_r <= ACT_NONE;
            pio_mindex_r <= 2'd0;
            pio_index_r  <= 5'd0;
            pio_din_r    <= 32'd0;
        end else if (grant_vld_s) begin
            ptr_r        <= grant_idx_s;
            pio_action_r <= win_action_s;
            pio_mindex_r <= win_mindex_s;
            pio_index_r  <= win_index_s;
            pio_din_r    <= win_din_s;
        end else begin
            ptr_r        <= ptr_r;
            pio_action_r <= ACT_NONE;
            pio_mindex_r <= 2'd0;
            pio_index_r  <= 5'd0;
            pio_din_r    <= 32'd0;
        end
    end

    // Per-machine lock: reload on a FIFO grant, otherwise count down to zero
    always_ff @(posedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (!reset) begin
                lock_r[m] <= 2'd0;
            end else if (grant_vld_s && win_fifo_s && (win_mindex_s == 2'(m))) begin
                lock_r[m] <= 2'd3;
            end else if (lock_r[m] != 2'd0) begin
                lock_r[m] <= lock_r[m] - 2'd1;
            end else begin
                lock_r[m] <= 2'd0;
            end
        end
    end

    // Two-stage PULL pipeline: response pulse lands two cycles after grant
    always_ff @(posedge clk) begin
        if (!reset) begin
            pull_oh_r   <= '0;
            rsp_valid_r <= '0;
        end else begin
            pull_oh_r   <= (grant_vld_s && (win_action_s == ACT_PULL)) ? grant_oh_s : '0;
            rsp_valid_r <= pull_oh_r;
        end
    end

    assign req_ready  = grant_oh_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_data   = pio_dout;
    assign pio_action = pio_action_r;
    assign pio_mindex = pio_mindex_r;
    assign pio_index  = pio_index_r;
    assign pio_din    = pio_din_r;

endmodule

// File: tb/tb_pio_cmd_arbiter.sv
// Testbench for pio_cmd_arbiter: directed scenarios with literal expectations
// followed by randomized traffic checked cycle by cycle against a behavioural
// model (last-grant requester, per-machine last FIFO-access cycle, response list).

module tb_pio_cmd_arbiter;

    localparam int NREQ = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [4*NREQ-1:0]   req_action;
    logic [2*NREQ-1:0]   req_mindex;
    logic [5*NREQ-1:0]   req_index;
    logic [32*NREQ-1:0]  req_din;
    logic [NREQ-1:0]     rsp_valid;
    logic [31:0]         rsp_data;
    logic [3:0]          pio_action;
    logic [1:0]          pio_mindex;
    logic [4:0]          pio_index;
    logic [31:0]         pio_din;
    logic [31:0]         pio_dout;
    logic [3:0]          pio_full;
    logic [3:0]          pio_empty;

    always #5 clk = ~clk;

    pio_cmd_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_action (req_action),
        .req_mindex (req_mindex),
        .req_index  (req_index),
        .req_din    (req_din),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .pio_action (pio_action),
        .pio_mindex (pio_mindex),
        .pio_index  (pio_index),
        .pio_din    (pio_din),
        .pio_dout   (pio_dout),
        .pio_full   (pio_full),
        .pio_empty  (pio_empty)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    typedef struct { int due; int who; } rsp_t;
    rsp_t        rsp_q[$];
    int          cyc = 0;
    int          last_g = NREQ - 1;
    int          last_fifo[4];
    bit          model_live = 1'b0;
    bit          exp_fields_vld = 1'b0;
    logic [31:0] exp_act, exp_mi, exp_ix, exp_din;
    int          cur_grant = -1;

    // Snapshots of what the DUT showed in the last checked cycle
    logic [31:0] snap_ready, snap_act, snap_mi, snap_ix, snap_rsp, snap_rdata;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%h expected=%h", name, cyc, actual, expected);
        end
    endtask

    function automatic bit model_eligible(input int r);
        logic [3:0] a = req_action[4*r +: 4];
        int         m = int'(req_mindex[2*r +: 2]);
        bit         free = (cyc - last_fifo[m]) >= 4;
        if (!req_valid[r]) return 1'b0;
        if (a == 4'd4) return !pio_full[m] && free;
        if (a == 4'd3) return !pio_empty[m] && free;
        return 1'b1;
    endfunction

    function automatic int model_grant();
        if (!reset) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (model_eligible((last_g + k) % NREQ)) return (last_g + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check_cycle();
        logic [31:0] exp_ready;
        logic [31:0] exp_rsp;
        cur_grant = model_grant();
        exp_ready = 32'd0;
        if (cur_grant >= 0) exp_ready[cur_grant] = 1'b1;
        exp_rsp = 32'd0;
        foreach (rsp_q[i]) if (rsp_q[i].due == cyc) exp_rsp[rsp_q[i].who] = 1'b1;
        snap_ready = 32'(req_ready);
        snap_act   = 32'(pio_action);
        snap_mi    = 32'(pio_mindex);
        snap_ix    = 32'(pio_index);
        snap_rsp   = 32'(rsp_valid);
        snap_rdata = rsp_data;
        if (model_live) begin
            chk("req_ready", 32'(req_ready), exp_ready);
            chk("pio_action", 32'(pio_action), exp_act);
            if (exp_fields_vld) begin
                chk("pio_mindex", 32'(pio_mindex), exp_mi);
                chk("pio_index", 32'(pio_index), exp_ix);
                chk("pio_din", pio_din, exp_din);
            end
            chk("rsp_valid", 32'(rsp_valid), exp_rsp);
            if (exp_rsp != 32'd0) chk("rsp_data", rsp_data, pio_dout);
        end
    endtask

    task automatic update_model();
        int i;
        if (!reset) begin
            model_live = 1'b1;
            last_g = NREQ - 1;
            for (int m = 0; m < 4; m++) last_fifo[m] = -100;
            rsp_q.delete();
            exp_fields_vld = 1'b1;
            exp_act = 32'd0; exp_mi = 32'd0; exp_ix = 32'd0; exp_din = 32'd0;
        end else if (cur_grant >= 0) begin
            exp_fields_vld = 1'b1;
            exp_act = 32'(req_action[4*cur_grant +: 4]);
            exp_mi  = 32'(req_mindex[2*cur_grant +: 2]);
            exp_ix  = 32'(req_index[5*cur_grant +: 5]);
            exp_din = req_din[32*cur_grant +: 32];
            last_g  = cur_grant;
            if (exp_act == 32'd3 || exp_act == 32'd4) last_fifo[exp_mi] = cyc;
            if (exp_act == 32'd3) rsp_q.push_back('{due: cyc + 2, who: cur_grant});
        end else begin
            exp_fields_vld = 1'b0;
            exp_act = 32'd0;
        end
        i = 0;
        while (i < rsp_q.size()) begin
            if (rsp_q[i].due <= cyc) rsp_q.delete(i);
            else i++;
        end
        cyc++;
    endtask

    // Inputs are driven at the falling edge; outputs checked 1 time unit later
    task automatic tick();
        #1;
        check_cycle();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic set_req(input int r, input logic v, input logic [3:0] a, input logic [1:0] mi,
                           input logic [4:0] ix, input logic [31:0] d);
        req_valid[r]         = v;
        req_action[4*r +: 4] = a;
        req_mindex[2*r +: 2] = mi;
        req_index[5*r +: 5]  = ix;
        req_din[32*r +: 32]  = d;
    endtask

    task automatic clear_reqs();
        for (int r = 0; r < NREQ; r++) set_req(r, 1'b0, 4'd0, 2'd0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_reqs();
        pio_full = 4'd0;
        pio_empty = 4'hF;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] seq5 [6];
        reset = 1'b0;
        pio_dout = 32'd0;
        pio_full = 4'd0;
        pio_empty = 4'hF;
        clear_reqs();
        @(negedge clk);

        // Two INSTR requesters contend after reset
        do_reset();
        set_req(0, 1'b1, 4'd1, 2'd0, 5'd5, 32'h0000_1234);
        set_req(2, 1'b1, 4'd1, 2'd0, 5'd6, 32'h0000_ABCD);
        tick();
        chk("t1_ready_first", snap_ready, 32'h1);
        set_req(0, 1'b0, 4'd0, 2'd0, 5'd0, 32'd0);
        tick();
        chk("t1_ready_second", snap_ready, 32'h4);
        chk("t1_act_first", snap_act, 32'd1);
        chk("t1_idx_first", snap_ix, 32'd5);
        set_req(2, 1'b0, 4'd0, 2'd0, 5'd0, 32'd0);
        tick();
        chk("t1_act_second", snap_act, 32'd1);
        chk("t1_idx_second", snap_ix, 32'd6);

        // Continuous GRPS from everyone rotates 0,1,2,3,...
        do_reset();
        for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, 4'd5, 2'(r), 5'(r), 32'(r));
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t2_rotation", snap_ready, 32'h1 << (k % 4));
        end

        // PUSH blocked by a full TX FIFO, granted once it drains
        do_reset();
        pio_full = 4'b0100;
        set_req(1, 1'b1, 4'd4, 2'd2, 5'd0, 32'h55);
        tick();
        chk("t3_blocked", snap_ready, 32'h0);
        tick();
        chk("t3_blocked2", snap_ready, 32'h0);
        chk("t3_idle_act", snap_act, 32'd0);
        pio_full = 4'd0;
        tick();
        chk("t3_granted", snap_ready, 32'h2);
        clear_reqs();
        tick();
        chk("t3_push_act", snap_act, 32'd4);
        chk("t3_push_mi", snap_mi, 32'd2);

        // PULL response routed to requester 3 two cycles after grant
        do_reset();
        pio_empty = 4'd0;
        set_req(3, 1'b1, 4'd3, 2'd0, 5'd0, 32'd0);
        tick();
        chk("t4_grant", snap_ready, 32'h8);
        clear_reqs();
        tick();
        pio_dout = 32'hDEAD_BEEF;
        tick();
        chk("t4_rsp_valid", snap_rsp, 32'h8);
        chk("t4_rsp_data", snap_rdata, 32'hDEAD_BEEF);
        tick();
        chk("t4_rsp_once", snap_rsp, 32'h0);

        // Locked machine 1 leaves gaps; machine 3 interleaves
        do_reset();
        set_req(0, 1'b1, 4'd4, 2'd1, 5'd0, 32'h1);
        set_req(1, 1'b1, 4'd4, 2'd3, 5'd0, 32'h2);
        seq5 = '{32'h1, 32'h2, 32'h0, 32'h0, 32'h1, 32'h2};
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t5_lock_seq", snap_ready, seq5[k]);
        end

        // Reset right after a PULL grant drops the response
        do_reset();
        pio_empty = 4'd0;
        set_req(1, 1'b1, 4'd3, 2'd2, 5'd0, 32'd0);
        tick();
        chk("t6_grant", snap_ready, 32'h2);
        clear_reqs();
        reset = 1'b0;
        tick();
        chk("t6_ready_in_reset", snap_ready, 32'h0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_no_rsp", snap_rsp, 32'h0);
        end
        set_req(0, 1'b1, 4'd1, 2'd0, 5'd1, 32'h11);
        set_req(3, 1'b1, 4'd1, 2'd0, 5'd2, 32'h33);
        tick();
        chk("t6_req0_first", snap_ready, 32'h1);

        // Randomized traffic against the model
        clear_reqs();
        for (int n = 0; n < 3000; n++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!req_valid[r] || cur_grant == r) begin
                    if ($urandom_range(3) != 0) begin
                        int x = int'($urandom_range(9));
                        logic [3:0] a;
                        a = (x < 3) ? 4'd4 : (x < 6) ? 4'd3 : 4'($urandom_range(15));
                        set_req(r, 1'b1, a, 2'($urandom_range(3)), 5'($urandom_range(31)), $urandom);
                    end else begin
                        req_valid[r] = 1'b0;
                    end
                end else if ($urandom_range(19) == 0) begin
                    req_valid[r] = 1'b0;
                end
            end
            pio_full  = 4'($urandom & $urandom);
            pio_empty = 4'($urandom & $urandom);
            pio_dout  = $urandom;
            reset     = ($urandom_range(99) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
